// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder and the CPU controller.
// Access-size codes, FSM state encoding and the default data-segment base.
package dmem_pkg;

    localparam logic [1:0] FMT_WORD = 2'b00;
    localparam logic [1:0] FMT_HALF = 2'b01;
    localparam logic [1:0] FMT_BYTE = 2'b10;
    localparam logic [1:0] FMT_RSVD = 2'b11;

    localparam logic [31:0] BASE_ADDR_DEF = 32'h1001_0000;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_e;

endpackage

// File: rtl/dmem_lane_ctrl.sv
// Byte-lane steering for the data memory (combinational).
// Ports: fmt/off_lo in; wr_be, replicated wr_data, right-justified rd_data, align_err out.
module dmem_lane_ctrl
    import dmem_pkg::*;
(
    input  logic [1:0]  fmt,
    input  logic [1:0]  off_lo,
    input  logic [31:0] w_data,
    input  logic [31:0] rd_word,
    output logic [3:0]  wr_be,
    output logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        align_err
);

    always_comb begin
        wr_be     = 4'h0;
        wr_data   = w_data;
        rd_data   = 32'h0;
        align_err = 1'b0;
        unique case (fmt)
            FMT_WORD: begin
                wr_be     = 4'hF;
                rd_data   = rd_word;
                align_err = (off_lo != 2'b00);
            end
            FMT_HALF: begin
                wr_be     = off_lo[1] ? 4'b1100 : 4'b0011;
                wr_data   = {2{w_data[15:0]}};
                rd_data   = {16'h0, off_lo[1] ? rd_word[31:16]
                                              : rd_word[15:0]};
                align_err = off_lo[0];
            end
            FMT_BYTE: begin
                wr_be   = 4'b0001 << off_lo;
                wr_data = {4{w_data[7:0]}};
                rd_data = {24'h0, rd_word[{off_lo, 3'b000} +: 8]};
            end
            FMT_RSVD: begin
                align_err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the multi-cycle CPU: byte-lane word RAM,
// post-reset clear, range/alignment checks, registered right-justified reads.
// Ports: clk, rst, dmem_r, dmem_w, store_format_signal, data_addr, w_data in;
//        dmem_data, rd_valid, ready, addr_err out.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH          = 1024,
    parameter int          ADDR_W         = 10,
    parameter logic [31:0] BASE_ADDR      = BASE_ADDR_DEF,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dmem_r,
    input  logic        dmem_w,
    input  logic [1:0]  store_format_signal,
    input  logic [31:0] data_addr,
    input  logic [31:0] w_data,
    output logic [31:0] dmem_data,
    output logic        rd_valid,
    output logic        ready,
    output logic        addr_err
);

    logic [31:0] mem [DEPTH];

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [31:0]       dmem_data_q, dmem_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              addr_err_q, addr_err_d;

    logic [31:0]       off;
    logic [ADDR_W-1:0] idx;
    logic              range_err;
    logic              align_err;
    logic              bad;
    logic [3:0]        lane_be;
    logic [31:0]       lane_wdata;
    logic [31:0]       lane_rdata;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;

    // Unsigned offset: addresses below the base wrap high and fail range.
    assign off       = data_addr - BASE_ADDR;
    assign idx       = off[ADDR_W+1:2];
    assign range_err = |off[31:ADDR_W+2];
    assign bad       = range_err | align_err;

    dmem_lane_ctrl u_lane (
        .fmt       (store_format_signal),
        .off_lo    (off[1:0]),
        .w_data    (w_data),
        .rd_word   (mem[idx]),
        .wr_be     (lane_be),
        .wr_data   (lane_wdata),
        .rd_data   (lane_rdata),
        .align_err (align_err)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dmem_data_d = dmem_data_q;
        rd_valid_d  = 1'b0;
        addr_err_d  = 1'b0;
        mem_we      = 1'b0;
        mem_waddr   = idx;
        mem_be      = lane_be;
        mem_wdata   = lane_wdata;
        unique case (state_q)
            ST_INIT: begin
                mem_we    = 1'b1;
                mem_waddr = cnt_q;
                mem_be    = 4'hF;
                mem_wdata = 32'h0;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (dmem_r || dmem_w) begin
                    if (bad) begin
                        addr_err_d = 1'b1;
                    end else if (dmem_w) begin
                        // A read alongside a write is dropped and flagged.
                        mem_we     = 1'b1;
                        addr_err_d = dmem_r;
                    end else begin
                        rd_valid_d  = 1'b1;
                        dmem_data_d = lane_rdata;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if (CLEAR_ON_RESET) begin
                state_q <= ST_INIT;
            end else begin
                state_q <= ST_IDLE;
            end
            cnt_q       <= '0;
            dmem_data_q <= 32'h0;
            rd_valid_q  <= 1'b0;
            addr_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dmem_data_q <= dmem_data_d;
            rd_valid_q  <= rd_valid_d;
            addr_err_q  <= addr_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_be[i]) begin
                    mem[mem_waddr][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
    end

    assign dmem_data = dmem_data_q;
    assign rd_valid  = rd_valid_q;
    assign addr_err  = addr_err_q;
    assign ready     = (state_q == ST_IDLE);

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder serving the multi-cycle CPU's data port (dmem_r/dmem_w, data_addr, w_data, store_format_signal → dmem_data).
- Byte-addressed, little-endian word RAM with byte/half/word lanes; reads are registered and right-justified so the CPU's ext8/ext16 paths see the datum in bits [15:0]/[7:0].
- Includes a post-reset clear sequencer, alignment/range checking, and ready/valid status flags.

Parameters:
- DEPTH, 1024, number of 32-bit words (power of two).
- ADDR_W, 10, log2(DEPTH).
- BASE_ADDR, 32'h1001_0000, byte address of word 0.
- CLEAR_ON_RESET, 1, 1 = zero the whole array after reset; 0 = skip the clear.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- dmem_r  in  1  read request, one cycle.
- dmem_w  in  1  write request, one cycle.
- store_format_signal  in  2  access size: 00 word, 01 half, 10 byte, 11 reserved; applies to reads and writes.
- data_addr  in  32  byte address.
- w_data  in  32  store data, right-justified.
- dmem_data  out  32  read data, right-justified, zero-filled above the access size.
- rd_valid  out  1  dmem_data holds the result of the previous cycle's accepted read.
- ready  out  1  block accepts requests.
- addr_err  out  1  one-cycle pulse: the previous cycle's request was rejected.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. On reset: dmem_data=0, rd_valid=0, ready=0, addr_err=0, state=INIT (or IDLE if CLEAR_ON_RESET=0), clear counter=0.
- State INIT:
  - Writes 0 to word[cnt] each cycle and increments cnt.
  - After DEPTH cycles (cnt wraps from DEPTH-1), moves to IDLE.
  - ready=0; all requests are ignored without error.
- State IDLE: ready=1; requests are serviced as below.
- Reset mid-INIT or mid-access restarts INIT from cnt=0. A write pending in that cycle is dropped.
- Offset and index: off = data_addr - BASE_ADDR, idx = off[ADDR_W+1:2].
- Range error: off ≥ DEPTH*4 (unsigned, so addresses below BASE_ADDR also fail).
- Alignment error:
  - word with off[1:0]≠0;
  - half with off[0]=1;
  - format 11.
- Rejected request: no array change; addr_err=1 next cycle; rd_valid=0.
- Write (dmem_w=1, valid address): takes effect at this clock edge, using byte lanes:
  - word: all four lanes;
  - half: lanes {1,0} if off[1]=0, else {3,2}, taking w_data[15:0];
  - byte: lane off[1:0], taking w_data[7:0].
- Read (dmem_r=1, valid address): one-cycle latency.
  - Next cycle dmem_data = selected word, half (zero-extended), or byte (zero-extended); rd_valid=1.
  - The CPU applies sign extension itself.
- dmem_data holds its last value until the next accepted read. rd_valid is a single-cycle pulse.
- Read-after-write: a read in cycle N+1 of an address written in cycle N returns the new data.
- Simultaneous dmem_r and dmem_w: the write is performed, the read is dropped, and addr_err is pulsed. The CPU never issues this, so it is flagged.
- Back-to-back requests every cycle are supported, with no bubbles.

Decomposition:
- Shared package dmem_pkg:
  - FMT_WORD=2'b00, FMT_HALF=2'b01, FMT_BYTE=2'b10;
  - state encoding INIT/IDLE;
  - BASE_ADDR default.
- The CPU controller imports the same format constants for store_format_signal.
- One sub-module, dmem_lane_ctrl (combinational): from format and off[1:0], produces the 4-bit byte write-enable, the lane-replicated write data, the read-extract mux, and the align_err flag.
- The array, FSM and counter stay in dmem_responder.

Test Plan:
- Clear sequence: rst high 1 cycle, DEPTH=16 → ready=0 for exactly 16 cycles, then 1; read of every word then returns 0.
- Word round-trip: write word 0xDEADBEEF at 0x10010004; read word next cycle → dmem_data=0xDEADBEEF, rd_valid=1 one cycle later.
- Lane writes: write byte 0x5A at 0x10010009, then half 0x1234 at 0x1001000A; read word 0x10010008 → 0x1234_5A00. Read byte at 0x10010009 → 0x0000005A.
- Errors:
  - word read at 0x10010002 → addr_err=1, rd_valid=0;
  - half write at 0x10010001 → memory unchanged;
  - any access at BASE_ADDR-4 or BASE_ADDR+DEPTH*4 → addr_err=1.
- Collisions:
  - dmem_r and dmem_w together at 0x10010000 with w_data=0x11 → word becomes 0x11, addr_err=1, rd_valid=0;
  - a write followed immediately by a read of the same address returns 0x11.
- Reset mid-INIT: rst at clear cycle 5 → counter restarts, ready still 0 for DEPTH further cycles; requests during INIT give addr_err=0 and cause no writes.
